// File: rtl/m_execute_writeback_pkg.sv
`default_nettype none
// ============================================================================
// Module  : m_execute_writeback_pkg
// Brief   : Opcode constants and sequencer state encoding shared by the
//           execute/write-back block and its ALU.
// Revision: 1.0 - initial release
// ============================================================================
package m_execute_writeback_pkg;

  // Opcode field instr[7:4]; it is also the destination register number.
  localparam logic [3:0] OP_NOP = 4'd0;
  localparam logic [3:0] OP_NOT = 4'd1;
  localparam logic [3:0] OP_OR  = 4'd2;
  localparam logic [3:0] OP_AND = 4'd3;
  localparam logic [3:0] OP_ADD = 4'd4;
  localparam logic [3:0] OP_RLF = 4'd5;
  localparam logic [3:0] OP_RRT = 4'd6;
  localparam logic [3:0] OP_SLE = 4'd7;
  localparam logic [3:0] OP_SGE = 4'd8;
  localparam logic [3:0] OP_BFS = 4'd9;
  localparam logic [3:0] OP_JAL = 4'd10;
  localparam logic [3:0] OP_LLI = 4'd11;
  localparam logic [3:0] OP_LHI = 4'd12;
  localparam logic [3:0] OP_LW  = 4'd13;
  localparam logic [3:0] OP_SW  = 4'd14;
  localparam logic [3:0] OP_MOV = 4'd15;

  // Sequencer states
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_MEM  = 2'd2,
    S_WB   = 2'd3
  } state_t;

endpackage : m_execute_writeback_pkg
`default_nettype wire

// File: rtl/m_execute_writeback_alu.sv
`default_nettype none
// ============================================================================
// Module  : m_alu
// Brief   : Combinational result generator for the execute stage. Produces an
//           8-bit result (carries dropped); nop/lw/sw yield zero.
// Revision: 1.0 - initial release
// ============================================================================
module m_alu
  import m_execute_writeback_pkg::*;
(
  input  logic [3:0] i_opcode,
  input  logic [7:0] i_h,
  input  logic [7:0] i_l,
  input  logic [3:0] i_f,
  input  logic [7:0] i_pc,
  output logic [7:0] o_result
);

  // Select the result for the decoded opcode
  always_comb begin
    o_result = 8'h00;
    case (i_opcode)
      OP_NOT:  o_result = ~i_l;
      OP_OR:   o_result = i_h | i_l;
      OP_AND:  o_result = i_h & i_l;
      OP_ADD:  o_result = i_h + i_l;
      OP_RLF:  o_result = {i_l[6:0], i_l[7]};
      OP_RRT:  o_result = {i_l[0], i_l[7:1]};
      OP_SLE:  o_result = {7'd0, (i_h <= i_l)};
      OP_SGE:  o_result = {7'd0, (i_h >= i_l)};
      OP_BFS:  o_result = i_h | (8'd1 << i_l[2:0]);
      OP_JAL:  o_result = i_pc + 8'd1;
      OP_LLI:  o_result = {i_h[7:4], i_f};
      OP_LHI:  o_result = {i_f, i_h[3:0]};
      OP_MOV:  o_result = i_l;
      default: o_result = 8'h00;
    endcase
  end

endmodule : m_alu
`default_nettype wire

// File: rtl/m_execute_writeback.sv
`default_nettype none
// ============================================================================
// Module  : m_execute_writeback
// Brief   : Execute/write-back sequencer between fetch and the register file.
//           Latches one instruction with its operands, computes the result or
//           runs a memory access, then strobes the write-back port.
// Revision: 1.0 - initial release
// ============================================================================
module m_execute_writeback
  import m_execute_writeback_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16
)
(
  input  logic       w_clock,
  input  logic       w_reset,
  input  logic       w_instr_valid,
  output logic       w_ready,
  input  logic [7:0] w_bus_instr_word,
  input  logic [7:0] w_bus_high_reg,
  input  logic [7:0] w_bus_low_reg,
  input  logic [7:0] w_bus_pc,
  output logic [7:0] w_bus_write_back_value,
  output logic [3:0] w_bus_write_back_reg,
  output logic       w_write_back,
  output logic       w_jump,
  output logic [7:0] w_bus_jump_target,
  output logic       w_mem_req,
  output logic       w_mem_we,
  output logic [7:0] w_bus_mem_addr,
  output logic [7:0] w_bus_mem_wdata,
  input  logic [7:0] w_bus_mem_rdata,
  input  logic       w_mem_ack,
  output logic       w_mem_error
);

  localparam int CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

  state_t r_state;
  state_t w_next_state;

  logic [7:0]    r_instr;
  logic [7:0]    r_high;
  logic [7:0]    r_low;
  logic [7:0]    r_pc;
  logic [CW-1:0] r_cnt;
  logic [7:0]    r_wb_value;
  logic [3:0]    r_wb_reg;
  logic [7:0]    r_jump_target;
  logic          r_is_jal;
  logic          r_mem_we;
  logic [7:0]    r_mem_addr;
  logic [7:0]    r_mem_wdata;
  logic          r_mem_error;

  logic [3:0]    w_opcode;
  logic [7:0]    w_alu_result;
  logic          w_timeout;

  assign w_opcode  = r_instr[7:4];
  assign w_timeout = (r_cnt == CW'(MEM_TIMEOUT - 1));

  m_alu u_alu (
    .i_opcode (w_opcode),
    .i_h      (r_high),
    .i_l      (r_low),
    .i_f      (r_instr[3:0]),
    .i_pc     (r_pc),
    .o_result (w_alu_result)
  );

  // State register
  always_ff @(posedge w_clock) begin
    if (w_reset) r_state <= S_IDLE;
    else         r_state <= w_next_state;
  end

  // Next-state decode
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: if (w_instr_valid) w_next_state = S_EXEC;
      S_EXEC: begin
        if (w_opcode == OP_NOP)                          w_next_state = S_IDLE;
        else if (w_opcode == OP_LW || w_opcode == OP_SW) w_next_state = S_MEM;
        else                                             w_next_state = S_WB;
      end
      S_MEM: begin
        if (w_mem_ack)      w_next_state = r_mem_we ? S_IDLE : S_WB;
        else if (w_timeout) w_next_state = S_IDLE;
      end
      S_WB:    w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Operand latch, result/memory registers and timeout counter
  always_ff @(posedge w_clock) begin
    if (w_reset) begin
      r_instr       <= 8'h00;
      r_high        <= 8'h00;
      r_low         <= 8'h00;
      r_pc          <= 8'h00;
      r_cnt         <= '0;
      r_wb_value    <= 8'h00;
      r_wb_reg      <= 4'h0;
      r_jump_target <= 8'h00;
      r_is_jal      <= 1'b0;
      r_mem_we      <= 1'b0;
      r_mem_addr    <= 8'h00;
      r_mem_wdata   <= 8'h00;
      r_mem_error   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_instr_valid) begin
            r_instr <= w_bus_instr_word;
            r_high  <= w_bus_high_reg;
            r_low   <= w_bus_low_reg;
            r_pc    <= w_bus_pc;
          end
        end
        S_EXEC: begin
          r_cnt    <= '0;
          r_is_jal <= (w_opcode == OP_JAL);
          if (w_opcode == OP_LW) begin
            r_mem_addr <= r_low;
            r_mem_we   <= 1'b0;
          end else if (w_opcode == OP_SW) begin
            r_mem_addr  <= r_high;
            r_mem_wdata <= r_low;
            r_mem_we    <= 1'b1;
          end else if (w_opcode != OP_NOP) begin
            r_wb_value <= w_alu_result;
            r_wb_reg   <= w_opcode;
            if (w_opcode == OP_JAL) r_jump_target <= r_low;
          end
        end
        S_MEM: begin
          if (w_mem_ack) begin
            if (!r_mem_we) begin
              r_wb_value <= w_bus_mem_rdata;
              r_wb_reg   <= OP_LW;
            end
          end else if (w_timeout) begin
            r_mem_error <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign w_ready                = (r_state == S_IDLE);
  assign w_write_back           = (r_state == S_WB);
  assign w_jump                 = (r_state == S_WB) && r_is_jal;
  assign w_mem_req              = (r_state == S_MEM);
  assign w_mem_we               = r_mem_we;
  assign w_bus_mem_addr         = r_mem_addr;
  assign w_bus_mem_wdata        = r_mem_wdata;
  assign w_bus_write_back_value = r_wb_value;
  assign w_bus_write_back_reg   = r_wb_reg;
  assign w_bus_jump_target      = r_jump_target;
  assign w_mem_error            = r_mem_error;

endmodule : m_execute_writeback
`default_nettype wire

// File: tb/tb_m_execute_writeback.sv
`default_nettype none
// ============================================================================
// Module  : tb_m_execute_writeback
// Brief   : Self-checking bench for m_execute_writeback: directed cases plus
//           random instructions against a transaction-level reference model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_m_execute_writeback;

  localparam int TMO = 4;

  logic       w_clock = 1'b0;
  logic       w_reset;
  logic       w_instr_valid;
  logic       w_ready;
  logic [7:0] w_bus_instr_word;
  logic [7:0] w_bus_high_reg;
  logic [7:0] w_bus_low_reg;
  logic [7:0] w_bus_pc;
  logic [7:0] w_bus_write_back_value;
  logic [3:0] w_bus_write_back_reg;
  logic       w_write_back;
  logic       w_jump;
  logic [7:0] w_bus_jump_target;
  logic       w_mem_req;
  logic       w_mem_we;
  logic [7:0] w_bus_mem_addr;
  logic [7:0] w_bus_mem_wdata;
  logic [7:0] w_bus_mem_rdata;
  logic       w_mem_ack;
  logic       w_mem_error;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state: what the outputs must hold between strobes
  logic       m_err;
  logic [7:0] m_val;
  logic [3:0] m_reg;

  m_execute_writeback #(.MEM_TIMEOUT(TMO)) dut (
    .w_clock                (w_clock),
    .w_reset                (w_reset),
    .w_instr_valid          (w_instr_valid),
    .w_ready                (w_ready),
    .w_bus_instr_word       (w_bus_instr_word),
    .w_bus_high_reg         (w_bus_high_reg),
    .w_bus_low_reg          (w_bus_low_reg),
    .w_bus_pc               (w_bus_pc),
    .w_bus_write_back_value (w_bus_write_back_value),
    .w_bus_write_back_reg   (w_bus_write_back_reg),
    .w_write_back           (w_write_back),
    .w_jump                 (w_jump),
    .w_bus_jump_target      (w_bus_jump_target),
    .w_mem_req              (w_mem_req),
    .w_mem_we               (w_mem_we),
    .w_bus_mem_addr         (w_bus_mem_addr),
    .w_bus_mem_wdata        (w_bus_mem_wdata),
    .w_bus_mem_rdata        (w_bus_mem_rdata),
    .w_mem_ack              (w_mem_ack),
    .w_mem_error            (w_mem_error)
  );

  always #5 w_clock = ~w_clock;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Arithmetic statement of each opcode's result
  function automatic logic [7:0] ref_result(input int op, input int h, input int l,
                                            input int f, input int pc);
    int r;
    case (op)
      1:  r = 255 - l;
      2:  r = h | l;
      3:  r = h & l;
      4:  r = (h + l) % 256;
      5:  r = ((l * 2) % 256) + (l / 128);
      6:  r = (l / 2) + ((l % 2) * 128);
      7:  r = (h <= l) ? 1 : 0;
      8:  r = (h >= l) ? 1 : 0;
      9:  r = h | (1 << (l % 8));
      10: r = (pc + 1) % 256;
      11: r = (h / 16) * 16 + f;
      12: r = f * 16 + (h % 16);
      15: r = l;
      default: r = 0;
    endcase
    return 8'(r);
  endfunction

  task automatic tick();
    @(posedge w_clock);
    #1;
  endtask

  // Outputs in an idle (ready, nothing strobing) cycle
  task automatic chk_idle(input string tag);
    chk({tag, "_ready"}, w_ready, 1);
    chk({tag, "_req"}, w_mem_req, 0);
    chk({tag, "_wb"}, w_write_back, 0);
    chk({tag, "_jump"}, w_jump, 0);
    chk({tag, "_err"}, w_mem_error, m_err);
    chk({tag, "_val"}, w_bus_write_back_value, m_val);
    chk({tag, "_reg"}, w_bus_write_back_reg, m_reg);
  endtask

  task automatic apply_reset();
    w_reset = 1'b1;
    w_instr_valid = 1'b0;
    w_mem_ack = 1'b0;
    tick();
    w_reset = 1'b0;
    m_err = 1'b0;
    m_val = 8'h00;
    m_reg = 4'h0;
  endtask

  // Offer one instruction and follow it to completion. ack_at = S_MEM cycle
  // (1-based) in which ack is given; 0 = never. valid stays high with garbage
  // while the block is busy to show it is ignored.
  task automatic do_instr(input logic [7:0] ins, input logic [7:0] h, input logic [7:0] l,
                          input logic [7:0] pc, input int ack_at, input logic [7:0] rd,
                          input bit alu_ack_noise);
    int  op;
    bit  acked;
    logic [7:0] ev;
    op = int'(ins[7:4]);
    chk("accept_ready", w_ready, 1);
    w_instr_valid = 1'b1;
    w_bus_instr_word = ins;
    w_bus_high_reg = h;
    w_bus_low_reg = l;
    w_bus_pc = pc;
    tick();
    // Execute cycle
    w_bus_instr_word = 8'($urandom);
    w_bus_high_reg = 8'($urandom);
    w_bus_low_reg = 8'($urandom);
    w_bus_pc = 8'($urandom);
    chk("exec_ready", w_ready, 0);
    chk("exec_wb", w_write_back, 0);
    chk("exec_req", w_mem_req, 0);
    if (op == 0) begin
      tick();
      w_instr_valid = 1'b0;
      chk_idle("nop");
    end else if (op == 13 || op == 14) begin
      acked = 0;
      for (int k = 1; k <= TMO && !acked; k++) begin
        tick();
        chk("mem_req", w_mem_req, 1);
        chk("mem_ready", w_ready, 0);
        chk("mem_we", w_mem_we, (op == 14) ? 1 : 0);
        chk("mem_addr", w_bus_mem_addr, (op == 14) ? h : l);
        if (op == 14) chk("mem_wdata", w_bus_mem_wdata, l);
        if (k == ack_at) begin
          w_mem_ack = 1'b1;
          w_bus_mem_rdata = rd;
          acked = 1;
        end
      end
      tick();
      w_mem_ack = 1'b0;
      w_bus_mem_rdata = 8'($urandom);
      chk("mem_req_drop", w_mem_req, 0);
      if (!acked) m_err = 1'b1;
      if (acked && op == 13) begin
        m_val = rd;
        m_reg = 4'd13;
        chk("lw_wb", w_write_back, 1);
        chk("lw_jump", w_jump, 0);
        chk("lw_reg", w_bus_write_back_reg, m_reg);
        chk("lw_val", w_bus_write_back_value, m_val);
        chk("lw_ready", w_ready, 0);
        tick();
      end
      w_instr_valid = 1'b0;
      chk_idle("mem_end");
    end else begin
      ev = ref_result(op, int'(h), int'(l), int'(ins[3:0]), int'(pc));
      if (alu_ack_noise) w_mem_ack = 1'b1;
      tick();
      m_val = ev;
      m_reg = 4'(op);
      chk("alu_wb", w_write_back, 1);
      chk("alu_reg", w_bus_write_back_reg, m_reg);
      chk("alu_val", w_bus_write_back_value, m_val);
      chk("alu_jump", w_jump, (op == 10) ? 1 : 0);
      chk("alu_req", w_mem_req, 0);
      if (op == 10) chk("jal_target", w_bus_jump_target, l);
      tick();
      w_instr_valid = 1'b0;
      w_mem_ack = 1'b0;
      chk_idle("alu_end");
    end
  endtask

  initial begin
    w_reset = 1'b1;
    w_instr_valid = 1'b0;
    w_bus_instr_word = 8'h00;
    w_bus_high_reg = 8'h00;
    w_bus_low_reg = 8'h00;
    w_bus_pc = 8'h00;
    w_bus_mem_rdata = 8'h00;
    w_mem_ack = 1'b0;
    m_err = 1'b0;
    m_val = 8'h00;
    m_reg = 4'h0;
    tick();
    tick();
    // Reset state
    chk("rst_we", w_mem_we, 0);
    chk("rst_addr", w_bus_mem_addr, 8'h00);
    chk("rst_wdata", w_bus_mem_wdata, 8'h00);
    chk("rst_target", w_bus_jump_target, 8'h00);
    chk_idle("rst");
    w_reset = 1'b0;
    tick();

    // add r4=05, r9=FE
    do_instr(8'h49, 8'h05, 8'hFE, 8'h00, 0, 8'h00, 1'b0);
    chk("add_val_direct", w_bus_write_back_value, 8'h03);
    // lw addr 20, ack in third wait cycle
    do_instr(8'hD2, 8'h00, 8'h20, 8'h01, 3, 8'hA5, 1'b0);
    chk("lw_val_direct", w_bus_write_back_value, 8'hA5);
    // sw acked immediately: no write-back, value/reg hold
    do_instr(8'hE3, 8'h30, 8'h77, 8'h02, 1, 8'h00, 1'b0);
    // jal pc=10 low=40
    do_instr(8'hA5, 8'h00, 8'h40, 8'h10, 0, 8'h00, 1'b1);
    chk("jal_val_direct", w_bus_write_back_value, 8'h11);
    // nop
    do_instr(8'h07, 8'h12, 8'h34, 8'h03, 0, 8'h00, 1'b0);
    // timeout then sticky error
    do_instr(8'hD0, 8'h00, 8'h44, 8'h04, 0, 8'h00, 1'b0);
    chk("tmo_err_direct", w_mem_error, 1);
    do_instr(8'h23, 8'hF0, 8'h0F, 8'h05, 0, 8'h00, 1'b0);

    // Reset during S_EXEC
    w_instr_valid = 1'b1;
    w_bus_instr_word = 8'h4A;
    w_bus_high_reg = 8'h01;
    w_bus_low_reg = 8'h02;
    tick();
    chk("rexec_ready_before", w_ready, 0);
    apply_reset();
    chk_idle("rexec");
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_idle("rexec_after");
    end

    // Reset during S_MEM (second wait cycle)
    do_instr(8'hF1, 8'h00, 8'h5C, 8'h06, 0, 8'h00, 1'b0);
    w_instr_valid = 1'b1;
    w_bus_instr_word = 8'hD1;
    w_bus_low_reg = 8'h99;
    tick();
    w_instr_valid = 1'b1;
    w_bus_instr_word = 8'h41;
    tick();
    chk("rmem_req_before", w_mem_req, 1);
    tick();
    apply_reset();
    chk_idle("rmem");
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_idle("rmem_after");
    end

    // Random instructions
    for (int n = 0; n < 250; n++) begin
      do_instr(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
               int'($urandom_range(0, TMO)), 8'($urandom), 1'($urandom));
      if ($urandom_range(0, 3) == 0) tick();
      if ($urandom_range(0, 40) == 0) begin
        apply_reset();
        chk_idle("rand_rst");
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_m_execute_writeback
`default_nettype wire
